// File: rtl/hazard_bubble_unit_pkg.sv
// Shared definitions for the hazard bubble unit: control-bundle bit positions,
// FSM state encoding and the default bubble value.
package hazard_pkg;

  localparam int CTRL_REGDST   = 7;
  localparam int CTRL_ALUSRC   = 6;
  localparam int CTRL_ALUOP_HI = 5;
  localparam int CTRL_ALUOP_LO = 4;
  localparam int CTRL_MEMREAD  = 3;
  localparam int CTRL_MEMWRITE = 2;
  localparam int CTRL_MEMTOREG = 1;
  localparam int CTRL_REGWRITE = 0;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_STALL = 1'b1
  } state_e;

  localparam logic [7:0] BUBBLE_DEFAULT = 8'h00;

endpackage

// File: rtl/hazard_bubble_unit_if.sv
// Pipeline-side signal bundle of the hazard bubble unit. The stall_cnt output
// exists only when HAZARD_PERF_CNT_EN is defined.
interface hazard_bubble_unit_if #(
  parameter int CTRL_W = 8,
  parameter int REG_AW = 5
);
  logic [CTRL_W-1:0] ctrl_in;
  logic [REG_AW-1:0] ifid_rs;
  logic [REG_AW-1:0] ifid_rt;
  logic              ifid_uses_rt;
  logic [REG_AW-1:0] idex_rt;
  logic              flush;
  logic [CTRL_W-1:0] ctrl_out;
  logic              pc_write;
  logic              ifid_write;
  logic              bubble;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0]       stall_cnt;

  modport master (
    output ctrl_in, ifid_rs, ifid_rt, ifid_uses_rt, idex_rt, flush,
    input  ctrl_out, pc_write, ifid_write, bubble, stall_cnt
  );
  modport slave (
    input  ctrl_in, ifid_rs, ifid_rt, ifid_uses_rt, idex_rt, flush,
    output ctrl_out, pc_write, ifid_write, bubble, stall_cnt
  );
`else
  modport master (
    output ctrl_in, ifid_rs, ifid_rt, ifid_uses_rt, idex_rt, flush,
    input  ctrl_out, pc_write, ifid_write, bubble
  );
  modport slave (
    input  ctrl_in, ifid_rs, ifid_rt, ifid_uses_rt, idex_rt, flush,
    output ctrl_out, pc_write, ifid_write, bubble
  );
`endif
endinterface

// File: rtl/hazard_bubble_unit_detect.sv
// Load-use comparator: the load in EX writes a register the ID instruction reads.
module hazard_detect #(
  parameter int REG_AW = 5
) (
  input  logic              memread_i,
  input  logic [REG_AW-1:0] idex_rt_i,
  input  logic [REG_AW-1:0] ifid_rs_i,
  input  logic [REG_AW-1:0] ifid_rt_i,
  input  logic              uses_rt_i,
  output logic              haz_o
);
  logic rs_match;
  logic rt_match;

  // Register 0 is hardwired, so a match on it is never a real dependency.
  assign rs_match = (idex_rt_i == ifid_rs_i);
  assign rt_match = uses_rt_i && (idex_rt_i == ifid_rt_i);
  assign haz_o    = memread_i && (idex_rt_i != '0) && (rs_match || rt_match);

endmodule

// File: rtl/hazard_bubble_unit.sv
// Load-use stall controller owning the ID/EX control register; flush wins over all.
// Optional stall counter output enabled by HAZARD_PERF_CNT_EN.
module hazard_bubble_unit
  import hazard_pkg::*;
#(
  parameter int                CTRL_W       = 8,
  parameter int                MEMREAD_BIT  = CTRL_MEMREAD,
  parameter int                REG_AW       = 5,
  parameter int                STALL_CYCLES = 1,
  parameter logic [CTRL_W-1:0] BUBBLE_VAL   = CTRL_W'(BUBBLE_DEFAULT)
) (
  input logic                 clk,
  input logic                 rst_n,
  hazard_bubble_unit_if.slave bus
);

  // Entering STALL already spent one bubble in IDLE, hence the -2.
  localparam logic [2:0] CNT_INIT = (STALL_CYCLES > 1) ? 3'(STALL_CYCLES - 2) : 3'd0;

  state_e            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic              haz;
  logic              pc_write, ifid_write, bubble;

  hazard_detect #(.REG_AW(REG_AW)) u_detect (
    .memread_i (ctrl_q[MEMREAD_BIT]),
    .idex_rt_i (bus.idex_rt),
    .ifid_rs_i (bus.ifid_rs),
    .ifid_rt_i (bus.ifid_rt),
    .uses_rt_i (bus.ifid_uses_rt),
    .haz_o     (haz)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      ctrl_q  <= BUBBLE_VAL;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ctrl_q  <= ctrl_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ctrl_d  = ctrl_q;
    if (bus.flush) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      ctrl_d  = BUBBLE_VAL;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (haz) begin
            ctrl_d = BUBBLE_VAL;
            if (STALL_CYCLES > 1) begin
              state_d = ST_STALL;
              cnt_d   = CNT_INIT;
            end
          end else begin
            ctrl_d = bus.ctrl_in;
          end
        end
        ST_STALL: begin
          ctrl_d = BUBBLE_VAL;
          if (cnt_q == 3'd0) state_d = ST_IDLE;
          else               cnt_d   = cnt_q - 3'd1;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    pc_write   = 1'b1;
    ifid_write = 1'b1;
    bubble     = 1'b0;
    if (bus.flush) begin
      bubble = 1'b1;
    end else if (state_q == ST_STALL || haz) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      bubble     = 1'b1;
    end
  end

  assign bus.ctrl_out   = ctrl_q;
  assign bus.pc_write   = pc_write;
  assign bus.ifid_write = ifid_write;
  assign bus.bubble     = bubble;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                         stall_cnt_q <= '0;
    else if (bubble && !bus.flush && stall_cnt_q != '1) stall_cnt_q <= stall_cnt_q + 32'd1;
  end

  assign bus.stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_bubble_unit.sv
// Scoreboard bench: two instances (1-cycle and 3-cycle stall) driven by directed
// vectors; a negedge monitor pops queued expectations and compares.
module tb_hazard_bubble_unit;
  import hazard_pkg::*;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  hazard_bubble_unit_if #(.CTRL_W(8), .REG_AW(5)) if1 ();
  hazard_bubble_unit_if #(.CTRL_W(8), .REG_AW(5)) if3 ();

  hazard_bubble_unit #(.STALL_CYCLES(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
  hazard_bubble_unit #(.STALL_CYCLES(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(if3));

  typedef struct {
    bit         sel;
    logic [7:0] ctrl;
    logic       pc;
    logic       ifid;
    logic       bub;
    int         cnt;
    string      name;
  } exp_t;

  exp_t q[$];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic drive_if1(input logic [7:0] ci, input logic [4:0] rs, input logic [4:0] rt,
                           input logic ur, input logic [4:0] xr, input logic fl);
    if1.ctrl_in = ci; if1.ifid_rs = rs; if1.ifid_rt = rt;
    if1.ifid_uses_rt = ur; if1.idex_rt = xr; if1.flush = fl;
  endtask

  task automatic drive_if3(input logic [7:0] ci, input logic [4:0] rs, input logic [4:0] rt,
                           input logic ur, input logic [4:0] xr, input logic fl);
    if3.ctrl_in = ci; if3.ifid_rs = rs; if3.ifid_rt = rt;
    if3.ifid_uses_rt = ur; if3.idex_rt = xr; if3.flush = fl;
  endtask

  // One cycle of stimulus on the selected instance; the other sits idle.
  task automatic cyc(input bit sel, input logic rst, input logic [7:0] ci,
                     input logic [4:0] rs, input logic [4:0] rt, input logic ur,
                     input logic [4:0] xr, input logic fl,
                     input logic [7:0] eo, input logic ep, input logic ei, input logic eb,
                     input int ec, input string nm);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n = rst;
    if (sel) begin
      drive_if3(ci, rs, rt, ur, xr, fl);
      drive_if1(8'h00, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
    end else begin
      drive_if1(ci, rs, rt, ur, xr, fl);
      drive_if3(8'h00, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
    end
    e.sel = sel; e.ctrl = eo; e.pc = ep; e.ifid = ei; e.bub = eb; e.cnt = ec; e.name = nm;
    q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t       e;
      logic [7:0] a_ctrl;
      logic       a_pc, a_ifid, a_bub;
      e      = q.pop_front();
      a_ctrl = e.sel ? if3.ctrl_out   : if1.ctrl_out;
      a_pc   = e.sel ? if3.pc_write   : if1.pc_write;
      a_ifid = e.sel ? if3.ifid_write : if1.ifid_write;
      a_bub  = e.sel ? if3.bubble     : if1.bubble;
      n_total++;
      if (a_ctrl === e.ctrl && a_pc === e.pc && a_ifid === e.ifid && a_bub === e.bub)
        n_pass++;
      else
        $display("FAIL %s: got ctrl_out=%h pc_write=%b ifid_write=%b bubble=%b, expected %h %b %b %b",
                 e.name, a_ctrl, a_pc, a_ifid, a_bub, e.ctrl, e.pc, e.ifid, e.bub);
`ifdef HAZARD_PERF_CNT_EN
      if (e.cnt >= 0) begin
        logic [31:0] a_cnt;
        a_cnt = e.sel ? if3.stall_cnt : if1.stall_cnt;
        n_total++;
        if (a_cnt === 32'(e.cnt)) n_pass++;
        else $display("FAIL %s stall_cnt: got %0d, expected %0d", e.name, a_cnt, e.cnt);
      end
`endif
    end
  end

  initial begin
    int fill;
    rst_n = 1'b0;
    drive_if1(8'h00, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
    drive_if3(8'h00, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
    cyc(0, 0, 8'h00, 0, 0, 0, 0, 0, 8'h00, 1, 1, 0, 0, "reset_state");
    // no hazard: load then independent R-type
    cyc(0, 1, 8'h4B, 1, 2, 1, 0, 0, 8'h00, 1, 1, 0, -1, "nohaz_c1");
    cyc(0, 1, 8'h81, 3, 4, 1, 2, 0, 8'h4B, 1, 1, 0, -1, "nohaz_load_out");
    cyc(0, 1, 8'h00, 0, 0, 0, 4, 0, 8'h81, 1, 1, 0, -1, "nohaz_rtype_out");
    // load-use, 1 bubble
    cyc(0, 1, 8'h4B, 1, 2, 1, 0, 0, 8'h00, 1, 1, 0, -1, "lu1_load_in");
    cyc(0, 1, 8'h81, 5, 6, 1, 5, 0, 8'h4B, 0, 0, 1, -1, "lu1_stall");
    cyc(0, 1, 8'h81, 5, 6, 1, 5, 0, 8'h00, 1, 1, 0, -1, "lu1_bubble_release");
    cyc(0, 1, 8'h00, 0, 0, 0, 6, 0, 8'h81, 1, 1, 0, -1, "lu1_consumer_out");
    // register 0 never stalls
    cyc(0, 1, 8'h4B, 1, 2, 1, 0, 0, 8'h00, 1, 1, 0, -1, "r0_load_in");
    cyc(0, 1, 8'h81, 0, 3, 1, 0, 0, 8'h4B, 1, 1, 0, -1, "r0_no_stall");
    // rt match only counts when the ID instruction reads rt
    cyc(0, 1, 8'h4B, 1, 1, 1, 3, 0, 8'h81, 1, 1, 0, -1, "rt_load_in");
    cyc(0, 1, 8'h04, 1, 7, 0, 7, 0, 8'h4B, 1, 1, 0, -1, "rt_unused_no_stall");
    cyc(0, 1, 8'h4B, 2, 2, 1, 7, 0, 8'h04, 1, 1, 0, -1, "rt_load2_in");
    cyc(0, 1, 8'h04, 1, 7, 1, 7, 0, 8'h4B, 0, 0, 1, -1, "rt_used_stall");
    cyc(0, 1, 8'h04, 1, 7, 1, 7, 0, 8'h00, 1, 1, 0, -1, "rt_used_release");
    cyc(0, 1, 8'h00, 0, 0, 0, 7, 0, 8'h04, 1, 1, 0, -1, "rt_store_out");
    // back-to-back load-use: the released load stalls its own consumer
    cyc(0, 1, 8'h4B, 1, 8, 1, 0, 0, 8'h00, 1, 1, 0, -1, "b2b_load_in");
    cyc(0, 1, 8'h4B, 8, 9, 0, 8, 0, 8'h4B, 0, 0, 1, -1, "b2b_stall1");
    cyc(0, 1, 8'h4B, 8, 9, 0, 8, 0, 8'h00, 1, 1, 0, -1, "b2b_release1");
    cyc(0, 1, 8'h81, 9, 1, 1, 9, 0, 8'h4B, 0, 0, 1, -1, "b2b_stall2");
    cyc(0, 1, 8'h81, 9, 1, 1, 9, 0, 8'h00, 1, 1, 0, -1, "b2b_release2");
    cyc(0, 1, 8'h00, 0, 0, 0, 1, 0, 8'h81, 1, 1, 0, 4, "b2b_consumer_out");
    // load-use, 3 bubbles
    cyc(1, 1, 8'h4B, 1, 2, 1, 0, 0, 8'h00, 1, 1, 0, 0, "lu3_load_in");
    cyc(1, 1, 8'h81, 5, 6, 1, 5, 0, 8'h4B, 0, 0, 1, -1, "lu3_bubble1");
    cyc(1, 1, 8'h81, 5, 6, 1, 5, 0, 8'h00, 0, 0, 1, -1, "lu3_bubble2");
    cyc(1, 1, 8'h81, 5, 6, 1, 5, 0, 8'h00, 0, 0, 1, -1, "lu3_bubble3");
    cyc(1, 1, 8'h81, 5, 6, 1, 5, 0, 8'h00, 1, 1, 0, 3, "lu3_release");
    cyc(1, 1, 8'h00, 0, 0, 0, 6, 0, 8'h81, 1, 1, 0, -1, "lu3_consumer_out");
    // flush in the second cycle of a 3-cycle stall
    cyc(1, 1, 8'h4B, 1, 2, 1, 0, 0, 8'h00, 1, 1, 0, -1, "fl_load_in");
    cyc(1, 1, 8'h81, 5, 6, 1, 5, 0, 8'h4B, 0, 0, 1, 3, "fl_stall1");
    cyc(1, 1, 8'h81, 5, 6, 1, 5, 1, 8'h00, 1, 1, 1, 4, "fl_flush_cycle");
    cyc(1, 1, 8'h00, 0, 0, 0, 0, 0, 8'h00, 1, 1, 0, 4, "fl_back_idle");
    // async reset in the middle of a stall
    fill = $urandom_range(0, 2);
    for (int i = 0; i < fill; i++)
      cyc(1, 1, 8'h00, 0, 0, 0, 0, 0, 8'h00, 1, 1, 0, -1, "rst_fill");
    cyc(1, 1, 8'h4B, 1, 2, 1, 0, 0, 8'h00, 1, 1, 0, -1, "rst_load_in");
    cyc(1, 1, 8'h81, 5, 6, 1, 5, 0, 8'h4B, 0, 0, 1, -1, "rst_stall1");
    cyc(1, 1, 8'h81, 5, 6, 1, 5, 0, 8'h00, 0, 0, 1, -1, "rst_stall2");
    cyc(1, 0, 8'h81, 5, 6, 1, 5, 0, 8'h00, 1, 1, 0, 0, "rst_async_1");
    cyc(1, 0, 8'h81, 5, 6, 1, 5, 0, 8'h00, 1, 1, 0, 0, "rst_async_2");
    cyc(1, 1, 8'h81, 5, 6, 1, 5, 0, 8'h00, 1, 1, 0, -1, "rst_release");
    cyc(1, 1, 8'h00, 0, 0, 0, 6, 0, 8'h81, 1, 1, 0, -1, "rst_consumer_out");
    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    if (q.size() > 0) begin
      n_total++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
